// File: rtl/modadd_acc.sv
// modadd_acc: streaming mod-q accumulator for Kyber coefficients.
//
// The block takes a frame of LEN coefficients on a valid/ready input stream.
// It returns the frame sum mod Q_VALUE on a valid/ready output stream.
// Each coefficient is first brought into 0..Q-1 with one conditional
// subtraction. Each add then uses a single conditional correction, the same
// scheme as the combinational mod-q subtractor.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high, discards any partial/pending frame
//   in_valid   in_data is valid
//   in_ready   block can accept in_data (low only while holding a result)
//   in_data    coefficient, nominally 0..Q-1 (anything below 2Q is reduced)
//   out_valid  out_data holds a frame result
//   out_ready  downstream accepts out_data
//   out_data   frame sum mod Q, always 0..Q-1
//   busy       high while a frame is partially accumulated
module modadd_acc #(
  parameter int unsigned   LOGQ    = 12,
  parameter logic [LOGQ:0] Q_VALUE = 13'd3329,
  parameter int unsigned   LEN     = 256,
  parameter int unsigned   CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_data,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  localparam logic [CNTW-1:0] LastCnt = CNTW'(LEN - 1);
  localparam bit              LenOne  = (LEN == 1);

  state_e          state;
  logic [LOGQ-1:0] acc;
  logic [CNTW-1:0] cnt;

  logic [LOGQ-1:0] x;
  logic [LOGQ-1:0] acc_next;
  logic [LOGQ:0]   in_ext;
  logic [LOGQ:0]   in_sub;
  logic [LOGQ:0]   s;
  logic [LOGQ:0]   t;

  // Pre-reduction is one subtraction because the widest input is below 2Q.
  // The add needs one correction because acc + x <= 2Q-2. If s < Q, then
  // t = s - Q borrows and its top bit is set, so s is kept.
  always_comb begin
    in_ext   = {1'b0, in_data};
    in_sub   = in_ext - Q_VALUE;
    x        = (in_ext >= Q_VALUE) ? in_sub[LOGQ-1:0] : in_data;
    s        = {1'b0, acc} + {1'b0, x};
    t        = s - Q_VALUE;
    acc_next = t[LOGQ] ? s[LOGQ-1:0] : t[LOGQ-1:0];
  end

  // Both handshake outputs are decoded from state alone. So in_ready never
  // depends on in_valid, and out_valid never depends on out_ready.
  assign in_ready = (state != StHold);
  assign busy     = (state == StAcc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            acc <= x;
            cnt <= CNTW'(1);
            if (LenOne) begin
              state     <= StHold;
              out_data  <= x;
              out_valid <= 1'b1;
            end else begin
              state <= StAcc;
            end
          end
        end
        StAcc: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt + CNTW'(1);
            if (cnt == LastCnt) begin
              state     <= StHold;
              out_data  <= acc_next;
              out_valid <= 1'b1;
            end
          end
        end
        StHold: begin
          // out_data stays untouched here, so it is stable under backpressure.
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_modadd_acc.sv
// tb_modadd_acc: directed and randomized checks of modadd_acc.
// Two instances are used: one with LEN=4 and one with LEN=256.
// Expected sums come from plain integer arithmetic: sum(x mod Q) mod Q.
module tb_modadd_acc;

  localparam int Q = 3329;

  logic        clk;
  logic        rst;

  logic        v4, rdy4, ov4, or4, busy4;
  logic [11:0] d4, od4;
  logic        v256, rdy256, ov256, or256, busy256;
  logic [11:0] d256, od256;

  int checks = 0;
  int errors = 0;

  logic [11:0] frame_q[$];

  modadd_acc #(
    .LOGQ    (12),
    .Q_VALUE (13'd3329),
    .LEN     (4),
    .CNTW    (2)
  ) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v4),
    .in_ready  (rdy4),
    .in_data   (d4),
    .out_valid (ov4),
    .out_ready (or4),
    .out_data  (od4),
    .busy      (busy4)
  );

  modadd_acc #(
    .LOGQ    (12),
    .Q_VALUE (13'd3329),
    .LEN     (256),
    .CNTW    (8)
  ) u_dut256 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v256),
    .in_ready  (rdy256),
    .in_data   (d256),
    .out_valid (ov256),
    .out_ready (or256),
    .out_data  (od256),
    .busy      (busy256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit big, input logic val, input logic [11:0] d);
    if (big) begin
      v256 = val;
      d256 = d;
    end else begin
      v4 = val;
      d4 = d;
    end
  endtask

  // Offer one beat after `gaps` idle cycles and wait (bounded) for in_ready.
  task automatic beat(input bit big, input logic [11:0] d, input int gaps);
    int n;
    drive(big, 1'b0, d);
    repeat (gaps) tick();
    drive(big, 1'b1, d);
    n = 0;
    while (!(big ? rdy256 : rdy4) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL in_ready timeout: observed 0 expected 1");
    end
    tick();
    drive(big, 1'b0, 12'd0);
  endtask

  // Send frame_q and check the result against the model. Then drain the
  // result after a random delay.
  task automatic run_frame(input bit big, input string tag, input int gapmax);
    int sum;
    int exp;
    sum = 0;
    foreach (frame_q[i]) begin
      beat(big, frame_q[i], $urandom_range(0, gapmax));
      sum += int'(frame_q[i]) % Q;
    end
    exp = sum % Q;
    check({tag, " out_valid"}, 32'(big ? ov256 : ov4), 32'd1);
    check(tag, 32'(big ? od256 : od4), 32'(exp));
    repeat ($urandom_range(0, gapmax)) tick();
    if (big) or256 = 1'b1; else or4 = 1'b1;
    tick();
    or256 = 1'b0;
    or4   = 1'b0;
    check({tag, " drained"}, 32'(big ? ov256 : ov4), 32'd0);
  endtask

  task automatic load4(input logic [11:0] a, input logic [11:0] b,
                       input logic [11:0] c, input logic [11:0] e);
    frame_q.delete();
    frame_q.push_back(a);
    frame_q.push_back(b);
    frame_q.push_back(c);
    frame_q.push_back(e);
  endtask

  initial begin
    logic [11:0] held;
    rst   = 1'b1;
    v4    = 1'b0;
    d4    = '0;
    or4   = 1'b0;
    v256  = 1'b0;
    d256  = '0;
    or256 = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    check("reset out_valid", 32'(ov4), 32'd0);
    check("reset out_data", 32'(od4), 32'd0);
    check("reset busy", 32'(busy4), 32'd0);
    check("reset out_valid 256", 32'(ov256), 32'd0);
    rst = 1'b0;
    tick();
    check("in_ready after reset", 32'(rdy4), 32'd1);
    check("in_ready after reset 256", 32'(rdy256), 32'd1);

    // Largest in-range coefficients: 4 * 3328 mod Q = 3325.
    load4(12'd3328, 12'd3328, 12'd3328, 12'd3328);
    run_frame(1'b0, "max coeffs", 0);

    load4(12'd1, 12'd2, 12'd3, 12'd3323);
    run_frame(1'b0, "sum to zero", 0);

    // 4095 is pre-reduced to 766.
    load4(12'd4095, 12'd0, 12'd0, 12'd0);
    run_frame(1'b0, "pre-reduced", 0);

    // busy is high mid-frame and low again once the result is held.
    beat(1'b0, 12'd10, 0);
    check("busy mid-frame", 32'(busy4), 32'd1);
    beat(1'b0, 12'd20, 0);
    beat(1'b0, 12'd30, 0);
    beat(1'b0, 12'd3300, 0);
    check("latency out_valid", 32'(ov4), 32'd1);
    check("busy in hold", 32'(busy4), 32'd0);
    held = od4;
    check("backpressure sum", 32'(held), 32'((10 + 20 + 30 + 3300) % Q));
    // Backpressure: the result must stay put and input must be refused.
    v4 = 1'b1;
    d4 = 12'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold in_ready", 32'(rdy4), 32'd0);
      check("hold out_data stable", 32'(od4), 32'(held));
      check("hold out_valid", 32'(ov4), 32'd1);
    end
    v4  = 1'b0;
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    check("release out_valid", 32'(ov4), 32'd0);
    check("release in_ready", 32'(rdy4), 32'd1);
    load4(12'd1, 12'd2, 12'd3, 12'd3323);
    run_frame(1'b0, "frame after hold", 0);

    // Reset partway through a frame discards the partial sum.
    beat(1'b0, 12'd1000, 0);
    beat(1'b0, 12'd2000, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-frame reset busy", 32'(busy4), 32'd0);
    check("mid-frame reset out_valid", 32'(ov4), 32'd0);
    load4(12'd1, 12'd1, 12'd1, 12'd1);
    run_frame(1'b0, "after mid-frame reset", 0);

    // Random LEN=4 frames with input gaps and output stalls.
    for (int f = 0; f < 30; f++) begin
      load4(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
            12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      run_frame(1'b0, "random len4", 3);
    end

    // Random LEN=256 frames against the model.
    for (int f = 0; f < 40; f++) begin
      frame_q.delete();
      for (int i = 0; i < 256; i++) frame_q.push_back(12'($urandom_range(0, 4095)));
      run_frame(1'b1, "random len256", (f % 4 == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
